// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer and the decode-side
// offset path.
//   state_t       : fetch FSM state encodings
//   PC_INCR       : sequential PC increment (one 32-bit instruction)
//   OFFSET_W      : width of the signed branch/jump word offset
//   OFFSET_SHIFT  : word-to-byte scaling shift applied to the offset
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [31:0] PC_INCR      = 32'd4;
    localparam int          OFFSET_W     = 8;
    localparam int          OFFSET_SHIFT = 2;

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
// Purely combinational next-PC arithmetic. Produces the sequential address
// PC+4 and the redirect target PC+4 + (sign-extended word offset * 4).
// All arithmetic wraps modulo 2^32.
// Ports:
//   pc         in  32  current fetch address
//   offset_imm in   8  signed word offset from the instruction
//   pc4        out 32  pc + 4
//   target     out 32  pc + 4 + sext(offset_imm) << 2
// ---------------------------------------------------------------------------
module pc_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0]         pc,
    input  logic [OFFSET_W-1:0] offset_imm,
    output logic [31:0]         pc4,
    output logic [31:0]         target
);

    logic [31:0] byte_offset;

    // Sign-extend the word offset and scale it to a byte offset.
    assign byte_offset = {{(32 - OFFSET_W - OFFSET_SHIFT){offset_imm[OFFSET_W-1]}},
                          offset_imm, {OFFSET_SHIFT{1'b0}}};

    assign pc4    = pc + PC_INCR;
    assign target = pc4 + byte_offset;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Owns the CPU program counter and the instruction-memory read handshake.
// Each completed fetch (BUSYWAIT low) picks either PC+4 or the branch/jump
// target; a taken redirect can optionally insert one idle (READ=0) cycle.
// Optional feature, enabled by defining PC_TRAP_EN: any PC update above
// MEM_LIMIT or not word-aligned loads the value, raises a sticky TRAP and
// parks the sequencer in HALT until reset. Without it TRAP is tied 0.
// Ports:
//   CLK        in   1  system clock, rising-edge
//   RESET      in   1  synchronous active-low reset
//   BUSYWAIT   in   1  instruction memory busy
//   JUMP       in   1  unconditional jump for the completing instruction
//   BRANCH_EQ  in   1  BEQ decoded
//   BRANCH_NE  in   1  BNE decoded
//   ZERO       in   1  ALU zero flag
//   OFFSET_IMM in   8  signed word offset
//   PC         out 32  current fetch address (registered)
//   PC4        out 32  PC+4 (combinational)
//   READ       out  1  instruction read request (registered)
//   TAKEN      out  1  one-cycle redirect pulse
//   TRAP       out  1  sticky fetch-range error
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'd0,
    parameter bit          REDIRECT_BUBBLE = 1'b1,
    parameter logic [31:0] MEM_LIMIT       = 32'd1020
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BUSYWAIT,
    input  logic                JUMP,
    input  logic                BRANCH_EQ,
    input  logic                BRANCH_NE,
    input  logic                ZERO,
    input  logic [OFFSET_W-1:0] OFFSET_IMM,
    output logic [31:0]         PC,
    output logic [31:0]         PC4,
    output logic                READ,
    output logic                TAKEN,
    output logic                TRAP
);

    state_t      state, next_state;
    logic [31:0] pc_q, next_pc;
    logic        read_q, next_read;
    logic        taken_q, next_taken;
    logic [31:0] target;
    logic [31:0] new_pc;
    logic        take;

    pc_target_calc u_target_calc (
        .pc         (pc_q),
        .offset_imm (OFFSET_IMM),
        .pc4        (PC4),
        .target     (target)
    );

    // Redirect decision. Both branch bits together are always taken.
    assign take   = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
    assign new_pc = take ? target : PC4;

`ifdef PC_TRAP_EN
    logic trap_q, next_trap;
    logic out_of_range;

    assign out_of_range = (new_pc > MEM_LIMIT) || (new_pc[1:0] != 2'b00);
    assign TRAP         = trap_q;
`else
    logic unused_limit;

    assign unused_limit = ^MEM_LIMIT;
    assign TRAP         = 1'b0;
`endif

    // Next-state and next-output logic. HALT keeps every default, so it
    // simply freezes the sequencer until reset.
    always_comb begin
        next_state = state;
        next_pc    = pc_q;
        next_read  = read_q;
        next_taken = 1'b0;
`ifdef PC_TRAP_EN
        next_trap  = trap_q;
`endif
        case (state)
            IDLE: begin
                next_state = FETCH;
                next_read  = 1'b1;
            end
            FETCH: begin
                if (!BUSYWAIT) begin
                    next_pc    = new_pc;
                    next_taken = take;
                    if (take && REDIRECT_BUBBLE) begin
                        next_state = REDIRECT;
                        next_read  = 1'b0;
                    end
`ifdef PC_TRAP_EN
                    if (out_of_range) begin
                        next_trap  = 1'b1;
                        next_read  = 1'b0;
                        next_state = HALT;
                    end
`endif
                end
            end
            REDIRECT: begin
                next_state = FETCH;
                next_read  = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            read_q  <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state   <= next_state;
            pc_q    <= next_pc;
            read_q  <= next_read;
            taken_q <= next_taken;
        end
    end

`ifdef PC_TRAP_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= next_trap;
        end
    end
`endif

    assign PC    = pc_q;
    assign READ  = read_q;
    assign TAKEN = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed self-checking bench for pc_sequencer with default parameters
// (RESET_PC=0, REDIRECT_BUBBLE=1, MEM_LIMIT=1020). Inputs change 1 ns after
// each rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BUSYWAIT;
    logic        JUMP;
    logic        BRANCH_EQ;
    logic        BRANCH_NE;
    logic        ZERO;
    logic [7:0]  OFFSET_IMM;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        READ;
    logic        TAKEN;
    logic        TRAP;

    int vectors     = 0;
    int miscompares = 0;

    pc_sequencer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BUSYWAIT   (BUSYWAIT),
        .JUMP       (JUMP),
        .BRANCH_EQ  (BRANCH_EQ),
        .BRANCH_NE  (BRANCH_NE),
        .ZERO       (ZERO),
        .OFFSET_IMM (OFFSET_IMM),
        .PC         (PC),
        .PC4        (PC4),
        .READ       (READ),
        .TAKEN      (TAKEN),
        .TRAP       (TRAP)
    );

    // 10 ns clock period.
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle outputs.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ctrl();
        JUMP       = 1'b0;
        BRANCH_EQ  = 1'b0;
        BRANCH_NE  = 1'b0;
        ZERO       = 1'b0;
        OFFSET_IMM = 8'h00;
    endtask

    // Reset, release, then sequential stepping 0 -> 4 -> 8.
    task automatic test_reset();
        RESET    = 1'b0;
        BUSYWAIT = 1'b0;
        clear_ctrl();
        tick();
        tick();
        vectors++;
        if (PC !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_pc: got %h expected %h", PC, 32'd0);
        end
        vectors++;
        if ({READ, TAKEN, TRAP} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {READ, TAKEN, TRAP});
        end
        RESET = 1'b1;
        tick();
        vectors++;
        if (READ !== 1'b1 || PC !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL release_fetch: got READ=%b PC=%h expected READ=1 PC=0", READ, PC);
        end
        tick();
        vectors++;
        if (PC !== 32'd4) begin
            miscompares++;
            $display("[TB] FAIL step_4: got %h expected %h", PC, 32'd4);
        end
        tick();
        vectors++;
        if (PC !== 32'd8) begin
            miscompares++;
            $display("[TB] FAIL step_8: got %h expected %h", PC, 32'd8);
        end
    endtask

    // BUSYWAIT holds PC at 8 while JUMP toggles; release steps to 12, 16.
    task automatic test_busywait();
        BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            JUMP       = i[0] ? 1'b0 : 1'b1;
            OFFSET_IMM = 8'h10;
            tick();
            vectors++;
            if (PC !== 32'd8 || READ !== 1'b1 || TAKEN !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL busy_hold_%0d: got PC=%h READ=%b TAKEN=%b expected PC=8 READ=1 TAKEN=0",
                         i, PC, READ, TAKEN);
            end
        end
        BUSYWAIT = 1'b0;
        clear_ctrl();
        tick();
        vectors++;
        if (PC !== 32'd12) begin
            miscompares++;
            $display("[TB] FAIL busy_release: got %h expected %h", PC, 32'd12);
        end
        tick();
        vectors++;
        if (PC !== 32'd16) begin
            miscompares++;
            $display("[TB] FAIL step_16: got %h expected %h", PC, 32'd16);
        end
    endtask

    // BEQ taken backwards, redirect bubble, BNE not taken, both-branch taken.
    task automatic test_branch();
        BRANCH_EQ  = 1'b1;
        ZERO       = 1'b1;
        OFFSET_IMM = 8'hFE;
        tick();
        vectors++;
        if (PC !== 32'd12 || TAKEN !== 1'b1 || READ !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL beq_taken: got PC=%h TAKEN=%b READ=%b expected PC=c TAKEN=1 READ=0",
                     PC, TAKEN, READ);
        end
        // Inputs during the bubble must be ignored.
        BRANCH_EQ = 1'b0;
        JUMP      = 1'b1;
        tick();
        vectors++;
        if (PC !== 32'd12 || TAKEN !== 1'b0 || READ !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL redirect_bubble: got PC=%h TAKEN=%b READ=%b expected PC=c TAKEN=0 READ=1",
                     PC, TAKEN, READ);
        end
        JUMP      = 1'b0;
        BRANCH_NE = 1'b1;
        ZERO      = 1'b1;
        tick();
        vectors++;
        if (PC !== 32'd16 || TAKEN !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bne_not_taken_12: got PC=%h TAKEN=%b expected PC=10 TAKEN=0", PC, TAKEN);
        end
        tick();
        vectors++;
        if (PC !== 32'd20 || TAKEN !== 1'b0 || READ !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bne_not_taken_16: got PC=%h TAKEN=%b READ=%b expected PC=14 TAKEN=0 READ=1",
                     PC, TAKEN, READ);
        end
        // Both branch bits with ZERO=0: taken, target 24 + 4 = 28.
        BRANCH_EQ  = 1'b1;
        BRANCH_NE  = 1'b1;
        ZERO       = 1'b0;
        OFFSET_IMM = 8'h01;
        tick();
        vectors++;
        if (PC !== 32'd28 || TAKEN !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL both_branch: got PC=%h TAKEN=%b expected PC=1c TAKEN=1", PC, TAKEN);
        end
        clear_ctrl();
        tick();
    endtask

    // Backward jump from 0 wraps to FFFF_FFFC, increments wrap to 0, max jump.
    task automatic test_wrap();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        JUMP       = 1'b1;
        OFFSET_IMM = 8'hFE;
        tick();
        vectors++;
        if (PC !== 32'hFFFF_FFFC || TAKEN !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL neg_wrap: got PC=%h TAKEN=%b expected PC=fffffffc TAKEN=1", PC, TAKEN);
        end
        vectors++;
        if (PC4 !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL pc4_wrap: got %h expected %h", PC4, 32'd0);
        end
        clear_ctrl();
        tick();
        tick();
        vectors++;
        if (PC !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL inc_wrap: got %h expected %h", PC, 32'd0);
        end
        JUMP       = 1'b1;
        OFFSET_IMM = 8'h7F;
        tick();
        vectors++;
        if (PC !== 32'h0000_0200 || TAKEN !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL max_jump: got PC=%h TAKEN=%b expected PC=200 TAKEN=1", PC, TAKEN);
        end
        clear_ctrl();
        tick();
    endtask

    // Reset asserted during a stalled fetch and during the redirect bubble.
    task automatic test_reset_mid();
        BUSYWAIT = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        vectors++;
        if (PC !== 32'd0 || READ !== 1'b0 || TAKEN !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_busy: got PC=%h READ=%b TAKEN=%b expected PC=0 READ=0 TAKEN=0",
                     PC, READ, TAKEN);
        end
        BUSYWAIT = 1'b0;
        RESET    = 1'b1;
        tick();
        JUMP       = 1'b1;
        OFFSET_IMM = 8'h05;
        tick();
        vectors++;
        if (PC !== 32'd24 || TAKEN !== 1'b1 || READ !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL jump_24: got PC=%h TAKEN=%b READ=%b expected PC=18 TAKEN=1 READ=0",
                     PC, TAKEN, READ);
        end
        RESET = 1'b0;
        tick();
        vectors++;
        if (PC !== 32'd0 || READ !== 1'b0 || TAKEN !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_redirect: got PC=%h READ=%b TAKEN=%b expected PC=0 READ=0 TAKEN=0",
                     PC, READ, TAKEN);
        end
        clear_ctrl();
        RESET = 1'b1;
        tick();
    endtask

`ifdef PC_TRAP_EN
    // Jump past MEM_LIMIT traps and holds until reset.
    task automatic test_trap();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        JUMP       = 1'b1;
        OFFSET_IMM = 8'h7F;
        tick();
        tick();
        OFFSET_IMM = 8'h7D;
        tick();
        vectors++;
        if (PC !== 32'd1016 || TRAP !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pre_trap: got PC=%0d TRAP=%b expected PC=1016 TRAP=0", PC, TRAP);
        end
        tick();
        OFFSET_IMM = 8'h01;
        tick();
        for (int i = 0; i < 5; i++) begin
            BUSYWAIT = i[0];
            vectors++;
            if (PC !== 32'd1024 || TRAP !== 1'b1 || READ !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL trap_hold_%0d: got PC=%0d TRAP=%b READ=%b expected PC=1024 TRAP=1 READ=0",
                         i, PC, TRAP, READ);
            end
            tick();
        end
        BUSYWAIT = 1'b0;
        clear_ctrl();
        RESET = 1'b0;
        tick();
        vectors++;
        if (TRAP !== 1'b0 || PC !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL trap_clear: got PC=%h TRAP=%b expected PC=0 TRAP=0", PC, TRAP);
        end
        RESET = 1'b1;
    endtask
`else
    // Without the trap feature, out-of-range fetches are not flagged.
    task automatic test_trap();
        vectors++;
        if (TRAP !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL trap_tied: got %b expected 0", TRAP);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_busywait();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_trap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the CPU program counter.
- Consumes the branch/jump offset produced by the decode path (8-bit word offset, sign-extended, scaled ×4) and the PC+4 increment.
- Drives the instruction-memory read handshake and decides the next PC each fetch.
- Sits between the control unit/ALU ZERO flag and the instruction cache/memory.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- REDIRECT_BUBBLE, 1, 1 = insert one idle cycle (READ=0) after a taken redirect; 0 = fetch the target immediately.
- MEM_LIMIT, 32'd1020, highest legal word-aligned fetch address (used only with the optional feature).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-low reset; sampled on CLK rising edge.
- BUSYWAIT  input  1  instruction memory busy; 1 = current fetch not yet complete.
- JUMP  input  1  decoded unconditional jump for the instruction being completed.
- BRANCH_EQ  input  1  decoded BEQ.
- BRANCH_NE  input  1  decoded BNE.
- ZERO  input  1  ALU zero flag for the completing instruction.
- OFFSET_IMM  input  8  signed word offset from the instruction.
- PC  output  32  current fetch address (registered).
- PC4  output  32  PC+4 (combinational from PC).
- READ  output  1  instruction read request (registered).
- TAKEN  output  1  one-cycle pulse: the last completed instruction redirected the PC.
- TRAP  output  1  sticky fetch-range error (tied 0 when the feature is absent).

Behaviour:
- Reset: RESET==0 at a rising edge forces PC=RESET_PC, READ=0, TAKEN=0, TRAP=0, state=IDLE. Reset overrides everything, including mid-BUSYWAIT and REDIRECT.
- States: IDLE, FETCH, REDIRECT, HALT (HALT is reachable only with the optional feature).
- IDLE:
  - READ=0.
  - Next edge with RESET==1 → FETCH. Result: one cycle after reset release, READ=1.
- FETCH:
  - READ=1, PC held stable.
  - BUSYWAIT==1 at edge: hold PC, stay in FETCH, ignore JUMP/BRANCH_*/ZERO/OFFSET_IMM.
  - BUSYWAIT==0 at edge: the instruction completes this cycle, and the control inputs are sampled on this edge.
    - taken = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO).
    - target = PC4 + ({{22{OFFSET_IMM[7]}}, OFFSET_IMM, 2'b00}).
    - Not taken: PC<=PC4, stay in FETCH, TAKEN<=0.
    - Taken: PC<=target, TAKEN<=1. If REDIRECT_BUBBLE: go to REDIRECT with READ<=0. Otherwise stay in FETCH.
- REDIRECT:
  - READ=0 for exactly one cycle, PC held, TAKEN<=0.
  - Next state is FETCH.
- Control-input combinations:
  - BRANCH_EQ and BRANCH_NE both set → always taken. This is defined behaviour, not an error.
  - JUMP with any branch bits → taken.
- Arithmetic:
  - All PC arithmetic is modulo 2^32.
  - PC=32'hFFFF_FFFC not taken → PC=0.
  - Negative offsets wrap the same way.
- TAKEN lasts one cycle, coincident with the first cycle PC shows the target.
- PC4 never glitches while PC is stable.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined:
  - Any PC update whose new value is > MEM_LIMIT, or has bits[1:0]!=0, loads the value into PC.
  - It also sets TRAP=1, READ<=0 and state=HALT.
  - HALT persists until reset.
  - In HALT, BUSYWAIT and control inputs are ignored.
- Undefined: TRAP tied 0, no range check, HALT state absent.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE=2'd0, FETCH=2'd1, REDIRECT=2'd2, HALT=2'd3);
  - the PC increment constant 32'd4;
  - the OFFSET_IMM width (8) and shift amount (2).
- One natural sub-module is pc_target_calc: combinational PC4 and target from PC and OFFSET_IMM. It is reused by the decode-side offset path.
- FSM and PC register stay in pc_sequencer.

Test Plan:
- Reset then release, BUSYWAIT=0, no control: PC=0 with READ=0 at the first edge after release; READ=1 next cycle; PC steps 0→4→8→12 on successive edges.
- BUSYWAIT=1 for 3 cycles at PC=8 with JUMP=1 toggling: PC stays 8, READ stays 1. Drop BUSYWAIT with JUMP=0 → PC=12.
- PC=16, BRANCH_EQ=1, ZERO=1, OFFSET_IMM=8'hFE, BUSYWAIT=0:
  - PC=12, TAKEN=1 for one cycle.
  - With REDIRECT_BUBBLE=1, READ=0 for one cycle.
  - BRANCH_NE=1, ZERO=1 → PC=20, TAKEN=0.
- PC=32'hFFFF_FFFC, not taken → PC=0. JUMP with OFFSET_IMM=8'h7F from PC=0 → PC=32'h0000_0200.
- RESET low while in FETCH with BUSYWAIT=1 and in REDIRECT: next edge PC=RESET_PC, READ=0, TAKEN=0.
- With PC_TRAP_EN and MEM_LIMIT=1020: jump from PC=1016 with OFFSET_IMM=8'h01 → PC=1024, TRAP=1, READ=0, held across 5 cycles; reset clears TRAP.
